// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-style main controller.
//
// Sequences one instruction through FETCH, DECODE and the opcode-specific
// execute states, driving the datapath selects and write enables each cycle.
// All state changes on the rising edge of clk. The reset is asynchronous and
// active-high, and it forces every output low at once.
//
// Parameters
//   EXT_ISA    1: ADDI, J and BNE are decoded; 0: those opcodes are illegal
//   MEM_WAIT   1: memory states wait for mem_ready; 0: mem_ready is taken as 1
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   opcode       instruction[31:26] from the IR, stable from DECODE onward
//   funct        instruction[5:0]
//   zero         ALU zero flag
//   mem_ready    memory access completes this cycle
//   MemtoReg     register write data comes from memory
//   RegDst       destination register is rd (else rt)
//   IorD         memory address comes from ALUOut (else PC)
//   ALUSrcA      ALU A is register A (else PC)
//   IRWrite      load the instruction register
//   MemWrite     memory write strobe
//   RegWrite     register file write enable
//   PCEn         PC write enable
//   PCSrc        PC source: 00 ALU, 01 ALUOut, 10 jump target
//   ALUSrcB      ALU B: 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   ALUControl   ALU operation
//   state        current state code, for debug
//   illegal      one-cycle pulse on an unknown opcode or funct

module mc_control_fsm #(
   parameter bit EXT_ISA  = 1'b1,
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       IorD,
   output logic       ALUSrcA,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       PCEn,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecute  = 4'd6,
      StAluWb    = 4'd7,
      StBranch   = 4'd8,
      StAddiExec = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e     state_q;
   logic       funct_bad_q;  // EXECUTE saw an unknown funct; blocks the ALUWB write
   logic       mem_ok;
   logic       op_lw, op_sw, op_rtype, op_beq, op_bne, op_addi, op_j, op_legal;
   logic       funct_ok;
   logic [2:0] funct_ctl;
   logic [1:0] alu_op;

   // With MEM_WAIT=0 memory is assumed to answer in the same cycle.
   assign mem_ok = MEM_WAIT ? mem_ready : 1'b1;

   // Opcode decode; the extended opcodes vanish when EXT_ISA=0 so they fall
   // into the illegal path.
   assign op_lw    = (opcode == OpLw);
   assign op_sw    = (opcode == OpSw);
   assign op_rtype = (opcode == OpRtype);
   assign op_beq   = (opcode == OpBeq);
   assign op_bne   = EXT_ISA && (opcode == OpBne);
   assign op_addi  = EXT_ISA && (opcode == OpAddi);
   assign op_j     = EXT_ISA && (opcode == OpJ);
   assign op_legal = op_lw | op_sw | op_rtype | op_beq | op_bne | op_addi | op_j;

   // R-type funct decode; unknown functs fall back to add.
   always_comb begin
      funct_ok  = 1'b1;
      funct_ctl = 3'b010;
      case (funct)
         6'b100000: funct_ctl = 3'b010;
         6'b100010: funct_ctl = 3'b110;
         6'b100100: funct_ctl = 3'b000;
         6'b100101: funct_ctl = 3'b001;
         6'b101010: funct_ctl = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StFetch;
         funct_bad_q <= 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               if (mem_ok) state_q <= StDecode;
            end
            StDecode: begin
               if (op_lw || op_sw)        state_q <= StMemAdr;
               else if (op_rtype)         state_q <= StExecute;
               else if (op_beq || op_bne) state_q <= StBranch;
               else if (op_addi)          state_q <= StAddiExec;
               else if (op_j)             state_q <= StJump;
               else                       state_q <= StFetch;
            end
            StMemAdr: begin
               state_q <= op_sw ? StMemWrite : StMemRead;
            end
            StMemRead: begin
               if (mem_ok) state_q <= StMemWb;
            end
            StMemWrite: begin
               if (mem_ok) state_q <= StFetch;
            end
            StExecute: begin
               funct_bad_q <= ~funct_ok;
               state_q     <= StAluWb;
            end
            StAddiExec: begin
               state_q <= StAddiWb;
            end
            // MEMWB, ALUWB, BRANCH, ADDIWB, JUMP and the unused codes 12-15
            default: begin
               state_q <= StFetch;
            end
         endcase
      end
   end

   assign state = state_q;

   // Output decode of the current state. FETCH and BRANCH look at mem_ready
   // and zero in the same cycle, so these are not registered; rst gates them
   // so they drop without waiting for an edge.
   always_comb begin
      MemtoReg   = 1'b0;
      RegDst     = 1'b0;
      IorD       = 1'b0;
      ALUSrcA    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      PCEn       = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b010;
      illegal    = 1'b0;
      alu_op     = 2'b00;

      case (state_q)
         StFetch: begin
            ALUSrcB = 2'b01;
            IRWrite = mem_ok;
            PCEn    = mem_ok;
         end
         StDecode: begin
            ALUSrcB = 2'b11;
            illegal = ~op_legal;
         end
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StMemRead: begin
            IorD = 1'b1;
         end
         StMemWb: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         StMemWrite: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         StExecute: begin
            ALUSrcA = 1'b1;
            alu_op  = 2'b10;
            illegal = ~funct_ok;
         end
         StAluWb: begin
            RegDst   = 1'b1;
            RegWrite = ~funct_bad_q;
         end
         StBranch: begin
            ALUSrcA = 1'b1;
            alu_op  = 2'b01;
            PCSrc   = 2'b01;
            PCEn    = op_bne ? ~zero : zero;
         end
         StAddiExec: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StAddiWb: begin
            RegWrite = 1'b1;
         end
         StJump: begin
            PCSrc = 2'b10;
            PCEn  = 1'b1;
         end
         default: begin
         end
      endcase

      case (alu_op)
         2'b01:   ALUControl = 3'b110;
         2'b10:   ALUControl = funct_ctl;
         default: ALUControl = 3'b010;
      endcase

      if (rst) begin
         MemtoReg   = 1'b0;
         RegDst     = 1'b0;
         IorD       = 1'b0;
         ALUSrcA    = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         PCEn       = 1'b0;
         PCSrc      = 2'b00;
         ALUSrcB    = 2'b00;
         ALUControl = 3'b000;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: bench for mc_control_fsm.
//
// Two instances share opcode/funct/zero/rst: dut_m (EXT_ISA=1, MEM_WAIT=1) and
// dut_x (EXT_ISA=0, MEM_WAIT=0). Each instruction is expanded by the model into
// a per-cycle trace of expected output vectors, derived from the instruction
// class and the number of memory wait cycles. The compare process checks the
// instance under test against that trace on every falling edge.

module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready_m;
   logic       mem_ready_x;

   logic       m2r_m, rdst_m, iord_m, asa_m, irw_m, mw_m, rw_m, pcen_m, ill_m;
   logic [1:0] pcsrc_m, asb_m;
   logic [2:0] aluc_m;
   logic [3:0] st_m;
   logic       m2r_x, rdst_x, iord_x, asa_x, irw_x, mw_x, rw_x, pcen_x, ill_x;
   logic [1:0] pcsrc_x, asb_x;
   logic [2:0] aluc_x;
   logic [3:0] st_x;

   logic [19:0] act_m;
   logic [19:0] act_x;

   always #5 clk = ~clk;

   mc_control_fsm #(.EXT_ISA(1'b1), .MEM_WAIT(1'b1)) dut_m (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready_m),
      .MemtoReg(m2r_m), .RegDst(rdst_m), .IorD(iord_m), .ALUSrcA(asa_m),
      .IRWrite(irw_m), .MemWrite(mw_m), .RegWrite(rw_m), .PCEn(pcen_m),
      .PCSrc(pcsrc_m), .ALUSrcB(asb_m), .ALUControl(aluc_m), .state(st_m),
      .illegal(ill_m)
   );

   mc_control_fsm #(.EXT_ISA(1'b0), .MEM_WAIT(1'b0)) dut_x (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready_x),
      .MemtoReg(m2r_x), .RegDst(rdst_x), .IorD(iord_x), .ALUSrcA(asa_x),
      .IRWrite(irw_x), .MemWrite(mw_x), .RegWrite(rw_x), .PCEn(pcen_x),
      .PCSrc(pcsrc_x), .ALUSrcB(asb_x), .ALUControl(aluc_x), .state(st_x),
      .illegal(ill_x)
   );

   // Vector layout: state, MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite,
   // RegWrite, PCEn, PCSrc, ALUSrcB, ALUControl, illegal.
   assign act_m = {st_m, m2r_m, rdst_m, iord_m, asa_m, irw_m, mw_m, rw_m, pcen_m,
                   pcsrc_m, asb_m, aluc_m, ill_m};
   assign act_x = {st_x, m2r_x, rdst_x, iord_x, asa_x, irw_x, mw_x, rw_x, pcen_x,
                   pcsrc_x, asb_x, aluc_x, ill_x};

   typedef struct {
      bit          lit;   // literal check: got was captured by the stimulus
      int          dut;   // 0 dut_m, 1 dut_x, 2 both
      string       name;
      logic [19:0] got;
      logic [19:0] want;
   } chk_t;

   typedef struct {
      logic        mr;
      logic [19:0] v;
   } step_t;

   chk_t  chk_q[$];
   step_t trace[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   function automatic logic [19:0] ev(input int st, input int m2r, input int rd, input int iord,
                                      input int asa, input int irw, input int mw, input int rw,
                                      input int pcen, input int pcs, input int asb,
                                      input int aluc, input int ill);
      return {4'(st), 1'(m2r), 1'(rd), 1'(iord), 1'(asa), 1'(irw), 1'(mw), 1'(rw), 1'(pcen),
              2'(pcs), 2'(asb), 3'(aluc), 1'(ill)};
   endfunction

   function automatic bit fn_known(input logic [5:0] f);
      return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
             f == 6'b100101 || f == 6'b101010;
   endfunction

   function automatic int fn_ctl(input logic [5:0] f);
      if (f == 6'b100010) return 6;
      if (f == 6'b100100) return 0;
      if (f == 6'b100101) return 1;
      if (f == 6'b101010) return 7;
      return 2;
   endfunction

   task automatic cmp(input string nm, input logic [19:0] got, input logic [19:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h", nm, got, want);
      end
   endtask

   // The single compare process.
   always @(negedge clk) begin
      chk_t c;
      while (chk_q.size() != 0 && chk_q[0].lit) begin
         c = chk_q.pop_front();
         cmp(c.name, c.got, c.want);
      end
      if (chk_q.size() != 0) begin
         c = chk_q.pop_front();
         if (c.dut != 1) cmp({"m.", c.name}, act_m, c.want);
         if (c.dut != 0) cmp({"x.", c.name}, act_x, c.want);
      end
   end

   task automatic push_lit(input string nm, input logic [19:0] got, input logic [19:0] want);
      chk_t c;
      c.lit = 1'b1; c.dut = 0; c.name = nm; c.got = got; c.want = want;
      chk_q.push_back(c);
   endtask

   task automatic push_cyc(input int dut, input string nm, input logic [19:0] want);
      chk_t c;
      c.lit = 1'b0; c.dut = dut; c.name = nm; c.got = '0; c.want = want;
      chk_q.push_back(c);
   endtask

   task automatic add(input logic mr, input logic [19:0] v);
      step_t s;
      s.mr = mr; s.v = v;
      trace.push_back(s);
   endtask

   // Model: expand one instruction into its expected cycle trace.
   // fw / dw = cycles the memory holds mem_ready low in FETCH / data access.
   task automatic build(input int dut, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int fw, input int dw);
      bit    ext = (dut == 0);
      bit    hon = (dut == 0);
      bit    bad_fn = !fn_known(fn);
      string cls;
      trace.delete();
      if (op == 6'b100011)             cls = "lw";
      else if (op == 6'b101011)        cls = "sw";
      else if (op == 6'b000000)        cls = "r";
      else if (op == 6'b000100)        cls = "beq";
      else if (ext && op == 6'b000101) cls = "bne";
      else if (ext && op == 6'b001000) cls = "addi";
      else if (ext && op == 6'b000010) cls = "j";
      else                             cls = "bad";

      if (hon) repeat (fw) add(1'b0, ev(0, 0,0,0,0, 0,0,0,0, 0,1,2, 0));
      add(hon || fw == 0, ev(0, 0,0,0,0, 1,0,0,1, 0,1,2, 0));
      add(1'b0, ev(1, 0,0,0,0, 0,0,0,0, 0,3,2, (cls == "bad") ? 1 : 0));

      if (cls == "lw") begin
         add(1'b0, ev(2, 0,0,0,1, 0,0,0,0, 0,2,2, 0));
         if (hon) repeat (dw) add(1'b0, ev(3, 0,0,1,0, 0,0,0,0, 0,0,2, 0));
         add(hon || dw == 0, ev(3, 0,0,1,0, 0,0,0,0, 0,0,2, 0));
         add(1'b0, ev(4, 1,0,0,0, 0,0,1,0, 0,0,2, 0));
      end else if (cls == "sw") begin
         add(1'b0, ev(2, 0,0,0,1, 0,0,0,0, 0,2,2, 0));
         if (hon) repeat (dw) add(1'b0, ev(5, 0,0,1,0, 0,1,0,0, 0,0,2, 0));
         add(hon || dw == 0, ev(5, 0,0,1,0, 0,1,0,0, 0,0,2, 0));
      end else if (cls == "r") begin
         add(1'b0, ev(6, 0,0,0,1, 0,0,0,0, 0,0,fn_ctl(fn), bad_fn ? 1 : 0));
         add(1'b0, ev(7, 0,1,0,0, 0,0,bad_fn ? 0 : 1,0, 0,0,2, 0));
      end else if (cls == "beq" || cls == "bne") begin
         add(1'b0, ev(8, 0,0,0,1, 0,0,0,((cls == "beq") == (z == 1'b1)) ? 1 : 0, 1,0,6, 0));
      end else if (cls == "addi") begin
         add(1'b0, ev(9, 0,0,0,1, 0,0,0,0, 0,2,2, 0));
         add(1'b0, ev(10, 0,0,0,0, 0,0,1,0, 0,0,2, 0));
      end else if (cls == "j") begin
         add(1'b0, ev(11, 0,0,0,0, 0,0,0,1, 2,0,2, 0));
      end
   endtask

   task automatic play(input int dut, input string nm, input int n);
      int lim = (n < 0 || n > trace.size()) ? trace.size() : n;
      for (int i = 0; i < lim; i++) begin
         if (dut == 0) begin
            mem_ready_m = trace[i].mr;
            mem_ready_x = 1'b0;
         end else begin
            mem_ready_x = trace[i].mr;
            mem_ready_m = 1'b0;
         end
         push_cyc(dut, $sformatf("%s.%0d", nm, i), trace[i].v);
         @(posedge clk);
         #1;
      end
   endtask

   // lat is the hand-computed instruction latency in cycles.
   task automatic run(input int dut, input string nm, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input int fw, input int dw,
                      input int lat);
      opcode = op;
      funct  = fn;
      zero   = z;
      build(dut, op, fn, z, fw, dw);
      push_lit({nm, ".latency"}, 20'(trace.size()), 20'(lat));
      play(dut, nm, -1);
   endtask

   task automatic hold_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         push_cyc(2, $sformatf("rst%0d", i), 20'h0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      opcode      = 6'b0;
      funct       = 6'b0;
      zero        = 1'b0;
      mem_ready_m = 1'b0;
      mem_ready_x = 1'b0;
      @(posedge clk);
      #1;
      hold_reset(1);

      // dut_m: full ISA, honours mem_ready
      run(0, "lw_w2",   6'b100011, 6'b000000, 1'b0, 0, 2, 7);
      run(0, "lw_fw1",  6'b100011, 6'b000000, 1'b0, 1, 0, 6);
      run(0, "sw",      6'b101011, 6'b000000, 1'b0, 0, 0, 4);
      run(0, "sw_w1",   6'b101011, 6'b000000, 1'b0, 0, 1, 5);
      run(0, "slt",     6'b000000, 6'b101010, 1'b0, 0, 0, 4);
      run(0, "add",     6'b000000, 6'b100000, 1'b1, 0, 0, 4);
      run(0, "sub",     6'b000000, 6'b100010, 1'b0, 0, 0, 4);
      run(0, "and",     6'b000000, 6'b100100, 1'b0, 0, 0, 4);
      run(0, "or",      6'b000000, 6'b100101, 1'b0, 0, 0, 4);
      run(0, "badfn",   6'b000000, 6'b111111, 1'b0, 0, 0, 4);
      run(0, "beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, 3);
      run(0, "beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, 3);
      run(0, "bne_z1",  6'b000101, 6'b000000, 1'b1, 0, 0, 3);
      run(0, "bne_z0",  6'b000101, 6'b000000, 1'b0, 0, 0, 3);
      run(0, "addi",    6'b001000, 6'b000000, 1'b0, 0, 0, 4);
      run(0, "j",       6'b000010, 6'b000000, 1'b0, 0, 0, 3);
      run(0, "badop",   6'b111111, 6'b000000, 1'b0, 0, 0, 2);
      run(0, "add2",    6'b000000, 6'b100000, 1'b0, 0, 0, 4);

      // Reset arriving mid-MEMWRITE: MemWrite must drop before the next edge.
      opcode = 6'b101011;
      funct  = 6'b000000;
      zero   = 1'b0;
      build(0, opcode, funct, zero, 0, 3);
      play(0, "abort", 4);
      mem_ready_m = 1'b0;
      push_lit("abort.memwrite_before", 20'(mw_m), 20'd1);
      push_cyc(2, "abort.rst", 20'h0);
      #1 rst = 1'b1;
      #1;
      push_lit("abort.memwrite_async", 20'(mw_m), 20'd0);
      push_lit("abort.state_async", 20'(st_m), 20'd0);
      @(posedge clk);
      #1;
      hold_reset(1);

      // dut_x: base ISA only, mem_ready ignored
      run(1, "x_addi",  6'b001000, 6'b000000, 1'b0, 0, 0, 2);
      run(1, "x_j",     6'b000010, 6'b000000, 1'b0, 0, 0, 2);
      run(1, "x_bne",   6'b000101, 6'b000000, 1'b0, 0, 0, 2);
      run(1, "x_lw",    6'b100011, 6'b000000, 1'b0, 2, 3, 5);
      run(1, "x_sw",    6'b101011, 6'b000000, 1'b0, 1, 2, 4);
      run(1, "x_beq",   6'b000100, 6'b000000, 1'b0, 0, 0, 3);
      run(1, "x_sub",   6'b000000, 6'b100010, 1'b0, 0, 0, 4);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
